// File: rtl/tx_seq_recorder_fifo_pkg.sv
// Shared Tx arbiter types: the source encoding recorded by the sequence FIFO
// and the legal write/read mode encodings.
package Tx_Arbiter_Package;

  typedef enum logic [2:0] {
    NO_SOURCE = 3'd0,
    A2P_1     = 3'd1,
    A2P_2     = 3'd2,
    A2P_3     = 3'd3,
    A2P_4     = 3'd4,
    MASTER    = 3'd5,
    SLAVE     = 3'd6,
    DEBUG     = 3'd7
  } Tx_Arbiter_Sources_t;

  localparam logic [2:0] WrMode1 = 3'd1;
  localparam logic [2:0] WrMode2 = 3'd2;
  localparam logic [2:0] WrMode3 = 3'd3;
  localparam logic [2:0] WrMode4 = 3'd4;

  localparam logic [1:0] RdMode1 = 2'b01;
  localparam logic [1:0] RdMode2 = 2'b10;

endpackage

// File: rtl/tx_seq_recorder_fifo.sv
// Multi-port ordering FIFO: up to 4 pushes and 2 pops per cycle, two show-ahead heads.
// Define TX_SEQ_REC_ERR_FLAGS_EN to add sticky overflow/underflow outputs.
module tx_seq_recorder_fifo
  import Tx_Arbiter_Package::*;
#(
  parameter int unsigned FIFO_DEPTH = 16,
  localparam int unsigned ADDR_WIDTH = $clog2(FIFO_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [2:0]            wr_mode,
  input  Tx_Arbiter_Sources_t   wr_data_1,
  input  Tx_Arbiter_Sources_t   wr_data_2,
  input  Tx_Arbiter_Sources_t   wr_data_3,
  input  Tx_Arbiter_Sources_t   wr_data_4,
  input  logic                  rd_en,
  input  logic [1:0]            rd_mode,
  output Tx_Arbiter_Sources_t   rd_data_1,
  output Tx_Arbiter_Sources_t   rd_data_2,
  output logic [ADDR_WIDTH:0]   available,
  output logic                  empty,
  output logic                  full
`ifdef TX_SEQ_REC_ERR_FLAGS_EN
  ,
  output logic                  overflow,
  output logic                  underflow
`endif
);

  localparam int unsigned CntW     = ADDR_WIDTH + 1;
  localparam int unsigned NumLanes = 4;

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_p1;
  logic [CntW-1:0]       count_q, count_d;
  Tx_Arbiter_Sources_t   mem [FIFO_DEPTH];

  logic [2:0] n_wr, n_wr_acc;
  logic [1:0] n_rd, n_rd_acc;
  logic       wr_ok, rd_ok;

  always_comb begin
    n_wr = '0;
    if (wr_en) begin
      case (wr_mode)
        WrMode1, WrMode2, WrMode3, WrMode4: n_wr = wr_mode;
        default:                            n_wr = '0;
      endcase
    end
    n_rd = '0;
    if (rd_en) begin
      case (rd_mode)
        RdMode1: n_rd = 2'd1;
        RdMode2: n_rd = 2'd2;
        default: n_rd = '0;
      endcase
    end
  end

  // Both checks use the pre-edge count; a same-cycle pop never makes room for a push.
  assign wr_ok    = CntW'(n_wr) <= available;
  assign rd_ok    = CntW'(n_rd) <= count_q;
  assign n_wr_acc = wr_ok ? n_wr : '0;
  assign n_rd_acc = rd_ok ? n_rd : '0;

  always_comb begin
    wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(n_wr_acc);
    rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(n_rd_acc);
    count_d  = count_q + CntW'(n_wr_acc) - CntW'(n_rd_acc);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  Tx_Arbiter_Sources_t   lane_data [NumLanes];
  logic [ADDR_WIDTH-1:0] lane_addr [NumLanes];
  logic [NumLanes-1:0]   lane_en;

  assign lane_data[0] = wr_data_1;
  assign lane_data[1] = wr_data_2;
  assign lane_data[2] = wr_data_3;
  assign lane_data[3] = wr_data_4;

  for (genvar k = 0; k < NumLanes; k++) begin : g_lane
    assign lane_en[k]   = rst_n && (3'(k) < n_wr_acc);
    assign lane_addr[k] = wr_ptr_q + ADDR_WIDTH'(k);
  end

  always_ff @(posedge clk) begin
    for (int k = 0; k < NumLanes; k++) begin
      if (lane_en[k]) begin
        mem[lane_addr[k]] <= lane_data[k];
      end
    end
  end

  assign rd_ptr_p1 = rd_ptr_q + ADDR_WIDTH'(1);
  assign rd_data_1 = (count_q != '0) ? mem[rd_ptr_q] : NO_SOURCE;
  assign rd_data_2 = (count_q >= CntW'(2)) ? mem[rd_ptr_p1] : NO_SOURCE;
  assign available = CntW'(FIFO_DEPTH) - count_q;
  assign empty     = (count_q == '0);
  assign full      = (count_q == CntW'(FIFO_DEPTH));

`ifdef TX_SEQ_REC_ERR_FLAGS_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (!wr_ok) overflow <= 1'b1;
      if (!rd_ok) underflow <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_tx_seq_recorder_fifo.sv
// Directed bench for tx_seq_recorder_fifo with a queue reference for FIFO contents.
module tb_tx_seq_recorder_fifo;
  import Tx_Arbiter_Package::*;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                wr_en;
  logic [2:0]          wr_mode;
  Tx_Arbiter_Sources_t wr_data_1, wr_data_2, wr_data_3, wr_data_4;
  logic                rd_en;
  logic [1:0]          rd_mode;
  Tx_Arbiter_Sources_t rd_data_1, rd_data_2;
  logic [4:0]          available;
  logic                empty, full;
`ifdef TX_SEQ_REC_ERR_FLAGS_EN
  logic                overflow, underflow;
  logic                ovf_exp, unf_exp;
`endif

  int n_checks = 0;
  int n_errors = 0;
  Tx_Arbiter_Sources_t exp_q[$];

  tx_seq_recorder_fifo #(.FIFO_DEPTH(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en     (wr_en),
    .wr_mode   (wr_mode),
    .wr_data_1 (wr_data_1),
    .wr_data_2 (wr_data_2),
    .wr_data_3 (wr_data_3),
    .wr_data_4 (wr_data_4),
    .rd_en     (rd_en),
    .rd_mode   (rd_mode),
    .rd_data_1 (rd_data_1),
    .rd_data_2 (rd_data_2),
    .available (available),
    .empty     (empty),
    .full      (full)
`ifdef TX_SEQ_REC_ERR_FLAGS_EN
    ,
    .overflow  (overflow),
    .underflow (underflow)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic Tx_Arbiter_Sources_t src(input int i);
    return Tx_Arbiter_Sources_t'(3'((i % 7) + 1));
  endfunction

  // One clock: drive inputs, update the reference at the edge, sample 1 unit later.
  task automatic do_cycle(input logic we, input logic [2:0] wm,
                          input Tx_Arbiter_Sources_t d1, input Tx_Arbiter_Sources_t d2,
                          input Tx_Arbiter_Sources_t d3, input Tx_Arbiter_Sources_t d4,
                          input logic re, input logic [1:0] rm);
    int cnt, nw, nr;
    Tx_Arbiter_Sources_t d[4];
    d[0] = d1; d[1] = d2; d[2] = d3; d[3] = d4;
    cnt = exp_q.size();
    nw = 0;
    if (we && wm >= 3'd1 && wm <= 3'd4) nw = int'(wm);
    nr = 0;
    if (re && rm == 2'b01) nr = 1;
    else if (re && rm == 2'b10) nr = 2;
    wr_en = we; wr_mode = wm; rd_en = re; rd_mode = rm;
    wr_data_1 = d1; wr_data_2 = d2; wr_data_3 = d3; wr_data_4 = d4;
    @(posedge clk);
    if (!rst_n) begin
      exp_q.delete();
`ifdef TX_SEQ_REC_ERR_FLAGS_EN
      ovf_exp = 1'b0; unf_exp = 1'b0;
`endif
    end else begin
      if (nr <= cnt) for (int i = 0; i < nr; i++) void'(exp_q.pop_front());
      if (nw <= 16 - cnt) for (int i = 0; i < nw; i++) exp_q.push_back(d[i]);
`ifdef TX_SEQ_REC_ERR_FLAGS_EN
      if (nw > 16 - cnt) ovf_exp = 1'b1;
      if (nr > cnt) unf_exp = 1'b1;
`endif
    end
    #1;
    wr_en = 1'b0; wr_mode = '0; rd_en = 1'b0; rd_mode = '0;
  endtask

  task automatic wr(input logic [2:0] wm, input Tx_Arbiter_Sources_t d1,
                    input Tx_Arbiter_Sources_t d2, input Tx_Arbiter_Sources_t d3,
                    input Tx_Arbiter_Sources_t d4);
    do_cycle(1'b1, wm, d1, d2, d3, d4, 1'b0, 2'b00);
  endtask

  task automatic rd(input logic [1:0] rm);
    do_cycle(1'b0, 3'd0, NO_SOURCE, NO_SOURCE, NO_SOURCE, NO_SOURCE, 1'b1, rm);
  endtask

  task automatic check_state(input string tag);
    int n;
    n = exp_q.size();
    check({tag, ".avail"}, 32'(available), 32'(16 - n));
    check({tag, ".empty"}, 32'(empty), 32'(n == 0));
    check({tag, ".full"}, 32'(full), 32'(n == 16));
    check({tag, ".rd1"}, 32'(rd_data_1), (n >= 1) ? 32'(exp_q[0]) : 32'(NO_SOURCE));
    check({tag, ".rd2"}, 32'(rd_data_2), (n >= 2) ? 32'(exp_q[1]) : 32'(NO_SOURCE));
`ifdef TX_SEQ_REC_ERR_FLAGS_EN
    check({tag, ".ovf"}, 32'(overflow), 32'(ovf_exp));
    check({tag, ".unf"}, 32'(underflow), 32'(unf_exp));
`endif
  endtask

  initial begin
    rst_n = 1'b0;
    wr_en = 1'b0; wr_mode = '0; rd_en = 1'b0; rd_mode = '0;
    wr_data_1 = NO_SOURCE; wr_data_2 = NO_SOURCE; wr_data_3 = NO_SOURCE; wr_data_4 = NO_SOURCE;
`ifdef TX_SEQ_REC_ERR_FLAGS_EN
    ovf_exp = 1'b0; unf_exp = 1'b0;
`endif
    @(negedge clk);
    rd(2'b00);
    rd(2'b00);
    rst_n = 1'b1;
    rd(2'b00);
    check("reset.avail", 32'(available), 32'd16);
    check("reset.empty", 32'(empty), 32'd1);
    check("reset.full", 32'(full), 32'd0);
    check("reset.rd1", 32'(rd_data_1), 32'(NO_SOURCE));
    check("reset.rd2", 32'(rd_data_2), 32'(NO_SOURCE));
    check_state("reset");

    // Write three, pop two.
    wr(3'd3, A2P_1, A2P_2, MASTER, NO_SOURCE);
    check("w3.rd1", 32'(rd_data_1), 32'(A2P_1));
    check("w3.rd2", 32'(rd_data_2), 32'(A2P_2));
    check("w3.avail", 32'(available), 32'd13);
    rd(2'b10);
    check("r2.rd1", 32'(rd_data_1), 32'(MASTER));
    check("r2.rd2", 32'(rd_data_2), 32'(NO_SOURCE));
    check("r2.avail", 32'(available), 32'd15);
    rd(2'b01);
    check("r1.empty", 32'(empty), 32'd1);

    // Fill with four mode-4 writes, then an overflowing write.
    for (int i = 0; i < 4; i++) begin
      wr(3'd4, src(4*i), src(4*i+1), src(4*i+2), src(4*i+3));
    end
    check("fill.full", 32'(full), 32'd1);
    check("fill.avail", 32'(available), 32'd0);
    check("fill.rd1", 32'(rd_data_1), 32'(src(0)));
    check_state("fill");
    wr(3'd1, DEBUG, NO_SOURCE, NO_SOURCE, NO_SOURCE);
    check("ovf.full", 32'(full), 32'd1);
    check("ovf.rd1", 32'(rd_data_1), 32'(src(0)));
    check("ovf.rd2", 32'(rd_data_2), 32'(src(1)));
`ifdef TX_SEQ_REC_ERR_FLAGS_EN
    check("ovf.flag", 32'(overflow), 32'd1);
`endif
    check_state("ovf");

    // At full, a same-cycle pop must not make room for the push.
    do_cycle(1'b1, 3'd1, DEBUG, NO_SOURCE, NO_SOURCE, NO_SOURCE, 1'b1, 2'b01);
    check("fullrw.avail", 32'(available), 32'd1);
    check("fullrw.rd1", 32'(rd_data_1), 32'(src(1)));
    check_state("fullrw");
    for (int i = 0; i < 7; i++) begin
      rd(2'b10);
      check_state("drain");
    end
    rd(2'b01);
    check("drain.empty", 32'(empty), 32'd1);

    // Underflowing pop with one entry.
    wr(3'd1, A2P_3, NO_SOURCE, NO_SOURCE, NO_SOURCE);
    rd(2'b10);
    check("unf.rd1", 32'(rd_data_1), 32'(A2P_3));
    check("unf.avail", 32'(available), 32'd15);
`ifdef TX_SEQ_REC_ERR_FLAGS_EN
    check("unf.flag", 32'(underflow), 32'd1);
`endif
    rd(2'b01);
    check("unf.empty", 32'(empty), 32'd1);

    // Pointers at 4; move both to 13, then put one entry so wr_ptr=14.
    wr(3'd4, SLAVE, A2P_2, MASTER, A2P_4);
    rd(2'b10); rd(2'b10);
    wr(3'd4, A2P_1, DEBUG, A2P_3, SLAVE);
    rd(2'b10); rd(2'b10);
    wr(3'd1, A2P_2, NO_SOURCE, NO_SOURCE, NO_SOURCE);
    rd(2'b01);
    check_state("pre_wrap");
    wr(3'd1, MASTER, NO_SOURCE, NO_SOURCE, NO_SOURCE);
    // Mode-4 write lands at 14,15,0,1 while the entry at 13 is popped.
    do_cycle(1'b1, 3'd4, A2P_4, SLAVE, DEBUG, A2P_1, 1'b1, 2'b01);
    check("wrap.avail", 32'(available), 32'd12);
    check("wrap.rd1", 32'(rd_data_1), 32'(A2P_4));
    check("wrap.rd2", 32'(rd_data_2), 32'(SLAVE));
    rd(2'b01);
    check("wrap1.rd1", 32'(rd_data_1), 32'(SLAVE));
    check("wrap1.rd2", 32'(rd_data_2), 32'(DEBUG));
    rd(2'b10);
    check("wrap2.rd1", 32'(rd_data_1), 32'(A2P_1));
    check("wrap2.rd2", 32'(rd_data_2), 32'(NO_SOURCE));
    check("wrap2.avail", 32'(available), 32'd15);
    rd(2'b01);
    check_state("wrap_end");

    // Reset mid-stream with seven entries and a concurrent write.
    wr(3'd4, A2P_1, A2P_2, A2P_3, A2P_4);
    wr(3'd3, MASTER, SLAVE, DEBUG, NO_SOURCE);
    check("pre_rst.avail", 32'(available), 32'd9);
    rst_n = 1'b0;
    wr(3'd4, DEBUG, DEBUG, DEBUG, DEBUG);
    rst_n = 1'b1;
    check("rst.empty", 32'(empty), 32'd1);
    check("rst.avail", 32'(available), 32'd16);
    check("rst.rd1", 32'(rd_data_1), 32'(NO_SOURCE));
    rd(2'b00);
    check("post_rst.empty", 32'(empty), 32'd1);
    check_state("post_rst");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
